// File: rtl/c2f_chunk_buffer_if.sv
// c2f_chunk_buffer_if: host write, commit, consumer read/ack and error-flag
// signals of the C2F chunk ring buffer. The master side is the host plus the
// consumer; the slave side is the buffer itself.
interface c2f_chunk_buffer_if #(
   parameter int PW = 4,
   parameter int OW = 6
);
   logic              wrSop_in;
   logic [PW+OW-1:0]  wrAddr_in;
   logic              wrValid_in;
   logic [63:0]       wrData_in;
   logic              commitWr_in;
   logic [PW-1:0]     commitPtr_in;
   logic              dtAck_in;
   logic [OW-1:0]     rdOffset_in;
   logic [63:0]       rdData_out;
   logic [PW-1:0]     wrPtr_out;
   logic [PW-1:0]     rdPtr_out;
   logic [PW-1:0]     occupancy_out;
   logic              errClear_in;
   logic              errCommit_out;
   logic              errWrite_out;
   logic              errAck_out;

   modport master (
      output wrSop_in, wrAddr_in, wrValid_in, wrData_in,
      output commitWr_in, commitPtr_in, dtAck_in, rdOffset_in, errClear_in,
      input  rdData_out, wrPtr_out, rdPtr_out, occupancy_out,
      input  errCommit_out, errWrite_out, errAck_out
   );

   modport slave (
      input  wrSop_in, wrAddr_in, wrValid_in, wrData_in,
      input  commitWr_in, commitPtr_in, dtAck_in, rdOffset_in, errClear_in,
      output rdData_out, wrPtr_out, rdPtr_out, occupancy_out,
      output errCommit_out, errWrite_out, errAck_out
   );
endinterface

// File: rtl/c2f_chunk_buffer.sv
// c2f_chunk_buffer: ring of fixed-size chunks between host QW writes and the
// C2F chunk consumer. Holds the committed write pointer and the ack-driven
// read pointer, serves chunk-relative reads with one-cycle latency, and drops
// host writes aimed at chunks already handed to the consumer.
module c2f_chunk_buffer #(
   parameter int NUM_CHUNKS = 16,
   parameter int CHUNK_QWS  = 64
) (
   input logic                sysClk_in,
   input logic                sysRstN_in,
   c2f_chunk_buffer_if.slave  bus
);
   localparam int PW    = $clog2(NUM_CHUNKS);
   localparam int OW    = $clog2(CHUNK_QWS);
   localparam int AW    = PW + OW;
   localparam int DEPTH = NUM_CHUNKS * CHUNK_QWS;

   logic [63:0]   mem [DEPTH];
   logic [63:0]   rdDataQ;
   logic [AW-1:0] burstCnt;
   logic [AW-1:0] wrAddrSel;
   logic [AW-1:0] rdAddr;
   logic [PW-1:0] wrChunk;
   logic [PW-1:0] wrDist;
   logic [PW-1:0] commitDist;
   logic [PW-1:0] wrPtrQ;
   logic [PW-1:0] rdPtrQ;
   logic [PW-1:0] occQ;
   logic [PW-1:0] wrPtrNext;
   logic [PW-1:0] rdPtrNext;
   logic          wrProtected;
   logic          wrEnable;
   logic          commitOk;
   logic          ackOk;
   logic          errCommitQ;
   logic          errWriteQ;
   logic          errAckQ;

   // Write address selection, overwrite guard, commit/ack legality and next pointers
   always_comb begin
      wrAddrSel   = bus.wrSop_in ? bus.wrAddr_in : burstCnt;
      wrChunk     = wrAddrSel[AW-1:OW];
      wrDist      = wrChunk - rdPtrQ;
      wrProtected = (wrDist < occQ);
      wrEnable    = bus.wrValid_in && !wrProtected;
      commitDist  = bus.commitPtr_in - rdPtrQ;
      commitOk    = (commitDist >= occQ);
      ackOk       = bus.dtAck_in && (occQ != '0);
      wrPtrNext   = (bus.commitWr_in && commitOk) ? bus.commitPtr_in : wrPtrQ;
      rdPtrNext   = ackOk ? rdPtrQ + PW'(1) : rdPtrQ;
      rdAddr      = {rdPtrQ, bus.rdOffset_in};
   end

   // Host write port into the chunk RAM; contents survive reset
   always_ff @(posedge sysClk_in) begin
      if (wrEnable) begin
         mem[wrAddrSel] <= bus.wrData_in;
      end
   end

   // Registered consumer read; a same-cycle write to the same QW returns old data
   always_ff @(posedge sysClk_in or negedge sysRstN_in) begin
      if (!sysRstN_in) begin
         rdDataQ <= '0;
      end else begin
         rdDataQ <= mem[rdAddr];
      end
   end

   // Burst address counter advances on every valid QW, even a dropped one
   always_ff @(posedge sysClk_in or negedge sysRstN_in) begin
      if (!sysRstN_in) begin
         burstCnt <= '0;
      end else if (bus.wrValid_in) begin
         burstCnt <= wrAddrSel + AW'(1);
      end
   end

   // Ring pointers and occupancy derived from the next-state pointers
   always_ff @(posedge sysClk_in or negedge sysRstN_in) begin
      if (!sysRstN_in) begin
         wrPtrQ <= '0;
         rdPtrQ <= '0;
         occQ   <= '0;
      end else begin
         wrPtrQ <= wrPtrNext;
         rdPtrQ <= rdPtrNext;
         occQ   <= wrPtrNext - rdPtrNext;
      end
   end

   // Sticky error flags; a new error in the clearing cycle keeps the flag set
   always_ff @(posedge sysClk_in or negedge sysRstN_in) begin
      if (!sysRstN_in) begin
         errCommitQ <= 1'b0;
         errWriteQ  <= 1'b0;
         errAckQ    <= 1'b0;
      end else begin
         errCommitQ <= (bus.commitWr_in && !commitOk) || (errCommitQ && !bus.errClear_in);
         errWriteQ  <= (bus.wrValid_in && wrProtected) || (errWriteQ && !bus.errClear_in);
         errAckQ    <= (bus.dtAck_in && !ackOk) || (errAckQ && !bus.errClear_in);
      end
   end

   assign bus.rdData_out    = rdDataQ;
   assign bus.wrPtr_out     = wrPtrQ;
   assign bus.rdPtr_out     = rdPtrQ;
   assign bus.occupancy_out = occQ;
   assign bus.errCommit_out = errCommitQ;
   assign bus.errWrite_out  = errWriteQ;
   assign bus.errAck_out    = errAckQ;
endmodule

// File: tb/tb_c2f_chunk_buffer.sv
// tb_c2f_chunk_buffer: directed bench for the C2F chunk ring buffer with a
// table of commit/ack vectors and hand-written write/read/reset sequences.
module tb_c2f_chunk_buffer;
   logic sysClk;
   logic sysRstN;
   int   checks;
   int   passes;

   typedef struct {
      string      name;
      logic       commitWr;
      logic [3:0] commitPtr;
      logic       dtAck;
      logic       errClear;
      logic [3:0] expWr;
      logic [3:0] expRd;
      logic [3:0] expOcc;
      logic       expErrCommit;
      logic       expErrAck;
   } vec_t;

   vec_t vecs[9];

   c2f_chunk_buffer_if #(.PW(4), .OW(6)) bus ();

   c2f_chunk_buffer #(.NUM_CHUNKS(16), .CHUNK_QWS(64)) dut (
      .sysClk_in  (sysClk),
      .sysRstN_in (sysRstN),
      .bus        (bus)
   );

   // Free-running 10-unit clock
   initial begin
      sysClk = 1'b0;
      forever #5 sysClk = ~sysClk;
   end

   task automatic tick();
      @(posedge sysClk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end else begin
         passes++;
      end
   endtask

   task automatic idleInputs();
      bus.wrSop_in     = 1'b0;
      bus.wrAddr_in    = '0;
      bus.wrValid_in   = 1'b0;
      bus.wrData_in    = '0;
      bus.commitWr_in  = 1'b0;
      bus.commitPtr_in = '0;
      bus.dtAck_in     = 1'b0;
      bus.rdOffset_in  = '0;
      bus.errClear_in  = 1'b0;
   endtask

   task automatic writeQw(input logic sop, input logic [9:0] addr, input logic [63:0] data);
      bus.wrSop_in   = sop;
      bus.wrAddr_in  = addr;
      bus.wrValid_in = 1'b1;
      bus.wrData_in  = data;
      tick();
      bus.wrSop_in   = 1'b0;
      bus.wrValid_in = 1'b0;
   endtask

   task automatic readCheck(input string name, input logic [5:0] offset, input logic [63:0] expected);
      bus.rdOffset_in = offset;
      tick();
      checkOutput(name, bus.rdData_out, expected);
   endtask

   task automatic pulse(input logic commitWr, input logic [3:0] commitPtr,
                        input logic dtAck, input logic errClear);
      bus.commitWr_in  = commitWr;
      bus.commitPtr_in = commitPtr;
      bus.dtAck_in     = dtAck;
      bus.errClear_in  = errClear;
      tick();
      bus.commitWr_in  = 1'b0;
      bus.dtAck_in     = 1'b0;
      bus.errClear_in  = 1'b0;
   endtask

   task automatic applyStimulus(input vec_t v);
      pulse(v.commitWr, v.commitPtr, v.dtAck, v.errClear);
      checkOutput({v.name, ".wrPtr"}, 64'(bus.wrPtr_out), 64'(v.expWr));
      checkOutput({v.name, ".rdPtr"}, 64'(bus.rdPtr_out), 64'(v.expRd));
      checkOutput({v.name, ".occ"}, 64'(bus.occupancy_out), 64'(v.expOcc));
      checkOutput({v.name, ".errCommit"}, 64'(bus.errCommit_out), 64'(v.expErrCommit));
      checkOutput({v.name, ".errAck"}, 64'(bus.errAck_out), 64'(v.expErrAck));
   endtask

   // Main directed sequence
   initial begin
      checks = 0;
      passes = 0;

      //          name         cWr  cPtr  ack  clr  wr  rd  occ eC  eA
      vecs[0] = '{"cmtAck6",   1'b1, 4'd6, 1'b1, 1'b0, 4'd6, 4'd3, 4'd3,  1'b0, 1'b0};
      vecs[1] = '{"cmt4rej",   1'b1, 4'd4, 1'b0, 1'b0, 4'd6, 4'd3, 4'd3,  1'b1, 1'b0};
      vecs[2] = '{"cmt5rej",   1'b1, 4'd5, 1'b0, 1'b0, 4'd6, 4'd3, 4'd3,  1'b1, 1'b0};
      vecs[3] = '{"clrCmt",    1'b0, 4'd0, 1'b0, 1'b1, 4'd6, 4'd3, 4'd3,  1'b0, 1'b0};
      vecs[4] = '{"cmt2wrap",  1'b1, 4'd2, 1'b0, 1'b0, 4'd2, 4'd3, 4'd15, 1'b0, 1'b0};
      vecs[5] = '{"cmt7rej",   1'b1, 4'd7, 1'b0, 1'b0, 4'd2, 4'd3, 4'd15, 1'b1, 1'b0};
      vecs[6] = '{"cmt9clr",   1'b1, 4'd9, 1'b0, 1'b1, 4'd2, 4'd3, 4'd15, 1'b1, 1'b0};
      vecs[7] = '{"clrCmt2",   1'b0, 4'd0, 1'b0, 1'b1, 4'd2, 4'd3, 4'd15, 1'b0, 1'b0};
      vecs[8] = '{"ack1",      1'b0, 4'd0, 1'b1, 1'b0, 4'd2, 4'd4, 4'd14, 1'b0, 1'b0};

      idleInputs();
      sysRstN = 1'b0;
      #12;
      checkOutput("rst.wrPtr", 64'(bus.wrPtr_out), 64'd0);
      checkOutput("rst.rdPtr", 64'(bus.rdPtr_out), 64'd0);
      checkOutput("rst.occ", 64'(bus.occupancy_out), 64'd0);
      checkOutput("rst.rdData", bus.rdData_out, 64'd0);
      checkOutput("rst.errs", 64'({bus.errCommit_out, bus.errWrite_out, bus.errAck_out}), 64'd0);
      #10;
      sysRstN = 1'b1;
      tick();

      // Fill chunk 0 with 1..64, commit it and read it back
      for (int i = 0; i < 64; i++) begin
         writeQw(i == 0, 10'd0, 64'(i + 1));
      end
      pulse(1'b1, 4'd1, 1'b0, 1'b0);
      checkOutput("fill.wrPtr", 64'(bus.wrPtr_out), 64'd1);
      checkOutput("fill.occ", 64'(bus.occupancy_out), 64'd1);
      for (int k = 0; k < 64; k++) begin
         readCheck("fill.read", 6'(k), 64'(k + 1));
      end
      pulse(1'b0, 4'd0, 1'b1, 1'b0);
      checkOutput("ack0.rdPtr", 64'(bus.rdPtr_out), 64'd1);
      checkOutput("ack0.occ", 64'(bus.occupancy_out), 64'd0);

      // Burst across the end of the ring: {15,62},{15,63},{0,0},{0,1}
      writeQw(1'b1, 10'd1022, 64'hA0);
      writeQw(1'b0, 10'd0, 64'hA1);
      writeQw(1'b0, 10'd0, 64'hA2);
      writeQw(1'b0, 10'd0, 64'hA3);
      checkOutput("wrap.errWrite", 64'(bus.errWrite_out), 64'd0);
      pulse(1'b1, 4'd0, 1'b0, 1'b0);
      checkOutput("wrap.occ", 64'(bus.occupancy_out), 64'd15);
      for (int i = 0; i < 14; i++) begin
         pulse(1'b0, 4'd0, 1'b1, 1'b0);
      end
      checkOutput("wrap.rdPtr15", 64'(bus.rdPtr_out), 64'd15);
      readCheck("wrap.r15_62", 6'd62, 64'hA0);
      readCheck("wrap.r15_63", 6'd63, 64'hA1);
      pulse(1'b0, 4'd0, 1'b1, 1'b0);
      checkOutput("wrap.rdPtr0", 64'(bus.rdPtr_out), 64'd0);
      readCheck("wrap.r0_0", 6'd0, 64'hA2);
      readCheck("wrap.r0_1", 6'd1, 64'hA3);
      readCheck("wrap.r0_2", 6'd2, 64'd3);

      // Protected chunk: a write into committed chunk 2 is dropped
      writeQw(1'b1, 10'd133, 64'h5555);
      pulse(1'b1, 4'd3, 1'b0, 1'b0);
      checkOutput("prot.occ", 64'(bus.occupancy_out), 64'd3);
      writeQw(1'b1, 10'd133, 64'hBAD);
      checkOutput("prot.errWrite", 64'(bus.errWrite_out), 64'd1);
      bus.errClear_in = 1'b1;
      writeQw(1'b1, 10'd134, 64'hBAD2);
      bus.errClear_in = 1'b0;
      checkOutput("prot.clrLoses", 64'(bus.errWrite_out), 64'd1);
      pulse(1'b0, 4'd0, 1'b0, 1'b1);
      checkOutput("prot.cleared", 64'(bus.errWrite_out), 64'd0);
      pulse(1'b0, 4'd0, 1'b1, 1'b0);
      pulse(1'b0, 4'd0, 1'b1, 1'b0);
      checkOutput("prot.rdPtr", 64'(bus.rdPtr_out), 64'd2);
      readCheck("prot.kept", 6'd5, 64'h5555);

      // Commit/ack table starting from wrPtr=3, rdPtr=2
      for (int v = 0; v < 9; v++) begin
         applyStimulus(vecs[v]);
      end

      // Drain to empty, then ack on empty
      for (int i = 0; i < 14; i++) begin
         pulse(1'b0, 4'd0, 1'b1, 1'b0);
      end
      checkOutput("drain.rdPtr", 64'(bus.rdPtr_out), 64'd2);
      checkOutput("drain.occ", 64'(bus.occupancy_out), 64'd0);
      pulse(1'b0, 4'd0, 1'b1, 1'b0);
      checkOutput("ackEmpty.errAck", 64'(bus.errAck_out), 64'd1);
      checkOutput("ackEmpty.rdPtr", 64'(bus.rdPtr_out), 64'd2);
      pulse(1'b0, 4'd0, 1'b1, 1'b1);
      checkOutput("ackEmpty.clrLoses", 64'(bus.errAck_out), 64'd1);
      pulse(1'b0, 4'd0, 1'b0, 1'b1);
      checkOutput("ackEmpty.cleared", 64'(bus.errAck_out), 64'd0);
      pulse(1'b0, 4'd0, 1'b1, 1'b0);

      // Asynchronous reset in the middle of a burst
      readCheck("rst2.preRead", 6'd5, 64'h5555);
      writeQw(1'b1, 10'd202, 64'hC0);
      bus.wrValid_in = 1'b1;
      bus.wrData_in  = 64'hC1;
      @(posedge sysClk);
      #3;
      sysRstN = 1'b0;
      bus.wrValid_in = 1'b0;
      #1;
      checkOutput("rst2.rdData", bus.rdData_out, 64'd0);
      checkOutput("rst2.wrPtr", 64'(bus.wrPtr_out), 64'd0);
      checkOutput("rst2.rdPtr", 64'(bus.rdPtr_out), 64'd0);
      checkOutput("rst2.occ", 64'(bus.occupancy_out), 64'd0);
      checkOutput("rst2.errAck", 64'(bus.errAck_out), 64'd0);
      #3;
      sysRstN = 1'b1;
      writeQw(1'b0, 10'd0, 64'hD0);
      writeQw(1'b0, 10'd0, 64'hD1);
      writeQw(1'b0, 10'd0, 64'hD2);
      checkOutput("rst2.errWrite", 64'(bus.errWrite_out), 64'd0);
      readCheck("rst2.r0", 6'd0, 64'hD0);
      readCheck("rst2.r1", 6'd1, 64'hD1);
      readCheck("rst2.r2", 6'd2, 64'hD2);
      readCheck("rst2.r3", 6'd3, 64'd4);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule

// File: doc/c2f_chunk_buffer.md
# c2f_chunk_buffer

Card-to-FPGA (C2F) chunk ring buffer sitting directly upstream of the C2F chunk consumer. It accepts host QW writes decoded from inbound memory-write TLPs into a ring of fixed-size chunks, and publishes a host-committed write pointer. It maintains a read pointer advanced by the consumer's per-chunk acknowledge, and serves the consumer's chunk-relative QW reads with one-cycle latency. It also guards chunks already handed to the consumer against host overwrite.

## Interface
- NUM_CHUNKS, 16, chunks in the ring; power of two, ≥2. PW = log2(NUM_CHUNKS).
- CHUNK_QWS, 64, 64-bit QWs per chunk (512-byte chunk); power of two, ≥4. OW = log2(CHUNK_QWS).
- sysClk_in  input  1  sole clock; all logic on rising edge.
- sysRstN_in  input  1  reset, asynchronous assert, active-low.
- wrSop_in  input  1  first QW of a host write burst; wrAddr_in is sampled.
- wrAddr_in  input  PW+OW  QW address of burst start: {chunk, offset}.
- wrValid_in  input  1  wrData_in valid this cycle; must be high with wrSop_in.
- wrData_in  input  64  QW write data.
- commitWr_in  input  1  host register write of new write pointer.
- commitPtr_in  input  PW  new write-pointer value.
- dtAck_in  input  1  consumer finished chunk at rdPtr_out; one-cycle pulse.
- rdOffset_in  input  OW  QW offset within chunk rdPtr_out.
- rdData_out  output  64  registered read data.
- wrPtr_out  output  PW  committed write pointer (consumer's wrPtr).
- rdPtr_out  output  PW  read pointer (consumer's rdPtr; also mirrored to host).
- occupancy_out  output  PW  (wrPtr_out − rdPtr_out) mod NUM_CHUNKS.
- errClear_in  input  1  clears all sticky error flags.
- errCommit_out / errWrite_out / errAck_out  output  1 each  sticky error flags.

## Operation
- Storage: NUM_CHUNKS×CHUNK_QWS×64 simple dual-port RAM; write port host, read port consumer.
- Reset (async, while sysRstN_in low): wrPtr_out=0, rdPtr_out=0, occupancy_out=0, rdData_out=0, all err flags 0, burst address counter 0. RAM contents are not reset.
- Empty when wrPtr_out==rdPtr_out. Max occupancy NUM_CHUNKS−1; ring is never "full-equal".
- Write burst:
  - On wrSop_in & wrValid_in, the QW goes to wrAddr_in and the counter loads wrAddr_in+1.
  - On wrValid_in without wrSop_in, the QW goes to the counter, which increments.
  - The counter wraps mod NUM_CHUNKS×CHUNK_QWS.
  - wrValid_in low holds the counter.
- Write protection: a QW whose chunk index c satisfies (c − rdPtr_out) mod N < occupancy_out is dropped, and errWrite_out is set. The counter still advances.
- Commit: accepted iff (commitPtr_in − rdPtr_out) mod N ≥ occupancy_out, using pre-edge values. Accepted: wrPtr_out ← commitPtr_in. Rejected: wrPtr_out unchanged, errCommit_out set.
- Ack: dtAck_in with occupancy_out≠0 → rdPtr_out ← rdPtr_out+1 (mod N). dtAck_in when empty → ignored, errAck_out set.
- Simultaneous commit + ack: both apply. The commit check uses pre-ack rdPtr_out.
- Read: address {rdPtr_out, rdOffset_in}, registered.
- Read/write to the same address in the same cycle: rdData_out returns old data. This is only reachable for unprotected chunks.
- errClear_in clears flags. An error event in the same cycle wins (flag stays set).

## Timing
- Host write is visible to reads issued the cycle after wrValid_in.
- rdData_out at edge t+1 = RAM[{rdPtr_out(t), rdOffset_in(t)}]. One-cycle latency, no stall, no enable.
- wrPtr_out, rdPtr_out and occupancy_out update on the edge after commitWr_in / dtAck_in. occupancy_out is registered, recomputed from the next-state pointers.
- Error flags assert on the edge after the offending event.
- Throughput: one host QW and one consumer read every cycle, independently.

## Test plan
- Reset, then write QWs 1..64 to chunk 0 (sop at addr 0) and commit 1 → wrPtr_out=1, occupancy_out=1. Reads at offsets 0..63 return 1..64 one cycle later. dtAck_in → rdPtr_out=1, occupancy_out=0.
- Burst at addr {15,62} of 4 QWs → lands at {15,62},{15,63},{0,0},{0,1}, showing the wrap. Chunk 0 is unprotected when rdPtr_out=1 and occupancy_out=0, so all four are written and no error is raised.
- Commit 3 with rdPtr=0, then a write to chunk 2 → dropped, errWrite_out=1, RAM unchanged. errClear_in → 0.
- With wrPtr=5 and rdPtr=2, commit 4 → rejected, errCommit_out=1, wrPtr_out stays 5. Commit 1 (wrap, occupancy 15) → accepted.
- With wrPtr=3, rdPtr=2: commitWr_in(6) and dtAck_in in the same cycle → wrPtr_out=6, rdPtr_out=3, occupancy_out=3. dtAck_in when empty → errAck_out=1, rdPtr_out unchanged.
- Assert sysRstN_in low mid-burst, asynchronously between edges → all outputs reach reset values immediately. A burst without wrSop_in after release writes starting at address 0.
